noc_vc_flit_arbiter: RTL
========================

// Module: noc_vc_flit_arbiter
// PURPOSE
//  Shares one physical flit link between VCS virtual-channel requesters. Round-robin
//  arbitration at packet granularity (head..tail lock), per-VC credit counters for the
//  downstream VC buffers, and the VC id of every flit that goes out. Sits at each router
//  output port, between the per-VC input FIFOs and the link toward the next hop.
// PARAMETERS
//  VCS              2     number of virtual channels / requesters (>=2)
//  FLIT_DATA_WIDTH  64    width of the flit data field
//  CREDITS          4     downstream buffer depth per VC; credit counter reset value
//  LOCK_TIMEOUT     1024  stall cycles before o_lock_timeout is raised (feature only)
//  derived: FLIT_WIDTH = FLIT_DATA_WIDTH+3 {flit_type,head,tail,data} (MSB..LSB);
//           VC_WIDTH = max(1,$clog2(VCS)); CW = $clog2(CREDITS+1)
// PORTS
//  i_clk            in   1               clock
//  i_rst_n          in   1               asynchronous reset, active low
//  i_flit_valid     in   VCS             per-VC flit valid
//  o_flit_ready     out  VCS             per-VC flit accepted
//  i_flit           in   VCS*FLIT_WIDTH  per-VC flit; VC v at [v*FLIT_WIDTH +: FLIT_WIDTH]
//  o_flit_valid     out  1               output flit valid
//  i_flit_ready     in   1               downstream link ready
//  o_flit           out  FLIT_WIDTH      granted flit
//  o_vc             out  VC_WIDTH        VC of o_flit
//  i_credit_return  in   VCS             one credit returned for VC v, one pulse per cycle
//  o_lock_timeout   out  1               sticky lock-stall flag (0 when feature is off)
// BEHAVIOUR
//  - Transfer on VC v: o_flit_valid & i_flit_ready & grant[v]. Zero latency: the data path
//    is combinational from i_flit to o_flit/o_vc; o_flit_ready[v] = grant[v] & i_flit_ready.
//  - Eligible[v] = i_flit_valid[v] & (credit[v]!=0). UNLOCKED: grant goes to the first
//    eligible VC scanning rr_ptr, rr_ptr+1, ... mod VCS. LOCKED(lvc): only lvc can be
//    granted; if lvc is ineligible, o_flit_valid=0 and no other VC is granted.
//  - o_flit_valid = |grant. o_flit/o_vc are don't-care when o_flit_valid=0.
//  - FSM: UNLOCKED -> LOCKED(v) on a transfer with head=1, tail=0. LOCKED -> UNLOCKED on a
//    transfer with tail=1. A head=1, tail=1 flit is a single-flit packet; state stays.
//  - rr_ptr: updates to (v+1) mod VCS on every transfer with tail=1; otherwise holds.
//  - Non-head flits while UNLOCKED are arbitrated like heads. No protocol check is made.
//  - credit[v]: -1 on a transfer on v; +1 on i_credit_return[v]; both in one cycle -> no
//    change. A return at credit==CREDITS is ignored (saturate). A transfer at 0 is impossible.
//  - Reset (asserted at any time, including mid-packet): state UNLOCKED, rr_ptr=0,
//    credit[*]=CREDITS, o_lock_timeout=0. o_flit_valid=0 and o_flit_ready=0 while
//    i_rst_n=0. The in-flight packet is abandoned; the bench must also reset upstream.
// CONFIGURATION
//  NOC_VC_ARB_LOCK_TIMEOUT_EN defined: a counter with $clog2(LOCK_TIMEOUT+1) bits
//    increments each LOCKED cycle with no transfer and clears on any transfer or on unlock.
//    When it reaches LOCK_TIMEOUT, o_lock_timeout is set and stays 1 until reset. This
//    flag is diagnostic only; arbitration is unchanged.
//  Not defined: no counter is built; o_lock_timeout is tied to 0.
// TESTING
//  1 reset, VCS=2, both valid with single-flit packets (head=tail=1), ready=1 ->
//    grants go VC0,VC1,VC0,VC1; o_vc alternates 0,1; rr_ptr starts at 0.
//  2 VC0 sends a 3-flit packet while VC1 is valid throughout -> 3 consecutive VC0 flits,
//    then VC1; no VC1 flit is interleaved.
//  3 CREDITS=4, no returns, VC0 sends 5 single-flit packets -> 4 accepted; 5th stalls
//    (o_flit_ready[0]=0); one i_credit_return[0] pulse -> 5th is sent the next cycle.
//  4 lock on VC1 with credit[1]=0 while VC0 is valid -> o_flit_valid=0 and VC0 is not
//    granted until a VC1 credit returns.
//  5 transfer and i_credit_return on the same VC in the same cycle -> credit unchanged;
//    return at credit=CREDITS -> stays CREDITS.
//  6 feature on, LOCK_TIMEOUT=8, locked VC0 withholds its next flit -> o_lock_timeout=1
//    after 8 stall cycles and stays 1; reset mid-packet -> flag 0, credits restored to 4,
//    VC1 can be granted first.

Source files
------------

// File: rtl/noc_vc_flit_arbiter.sv
// Packet-locked round-robin arbiter sharing one flit link between VCS virtual channels,
// with per-VC downstream credits. Optional lock-stall diagnostic: NOC_VC_ARB_LOCK_TIMEOUT_EN.

module noc_vc_credit_ctr #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_take,
  input  logic i_ret,
  output logic o_avail
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_take && !i_ret)
      cnt_d = cnt_q - CW'(1);
    else if (i_ret && !i_take && cnt_q != CW'(CREDITS))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= CW'(CREDITS);
    else          cnt_q <= cnt_d;
  end

  assign o_avail = (cnt_q != '0);
endmodule

module noc_vc_flit_arbiter #(
  parameter  int VCS             = 2,
  parameter  int FLIT_DATA_WIDTH = 64,
  parameter  int CREDITS         = 4,
  parameter  int LOCK_TIMEOUT    = 1024,
  localparam int FLIT_WIDTH      = FLIT_DATA_WIDTH + 3,
  localparam int VC_WIDTH        = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int CW              = $clog2(CREDITS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [VCS-1:0]            i_flit_valid,
  output logic [VCS-1:0]            o_flit_ready,
  input  logic [VCS*FLIT_WIDTH-1:0] i_flit,
  output logic                      o_flit_valid,
  input  logic                      i_flit_ready,
  output logic [FLIT_WIDTH-1:0]     o_flit,
  output logic [VC_WIDTH-1:0]       o_vc,
  input  logic [VCS-1:0]            i_credit_return,
  output logic                      o_lock_timeout
);
  typedef struct packed {
    logic                       ftype;
    logic                       head;
    logic                       tail;
    logic [FLIT_DATA_WIDTH-1:0] data;
  } flit_t;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_e;

  if (VCS < 2 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("noc_vc_flit_arbiter: VCS must be >= 2 and LOCK_TIMEOUT >= 1");
  end

  state_e                          state_q, state_d;
  logic [VC_WIDTH-1:0]             lvc_q, lvc_d;
  logic [VC_WIDTH-1:0]             rr_q, rr_d;
  logic [VCS-1:0]                  avail, elig, grant;
  logic [VCS-1:0][FLIT_WIDTH-1:0]  flits;
  logic [VC_WIDTH-1:0]             gvc;
  flit_t                           sel;
  logic                            xfer;

  assign flits = i_flit;
  assign elig  = i_flit_valid & avail;

  for (genvar v = 0; v < VCS; v++) begin : g_vc
    noc_vc_credit_ctr #(.CREDITS(CREDITS), .CW(CW)) u_cred (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_take  (xfer & grant[v]),
      .i_ret   (i_credit_return[v]),
      .o_avail (avail[v])
    );
  end

  // Locked: only the owning VC may go, even if that idles the link.
  always_comb begin
    logic [VC_WIDTH:0] idx;
    logic              found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (state_q == ST_LOCKED) begin
      grant[lvc_q] = elig[lvc_q];
    end else begin
      for (int k = 0; k < VCS; k++) begin
        idx = {1'b0, rr_q} + (VC_WIDTH+1)'(k);
        if (idx >= (VC_WIDTH+1)'(VCS)) idx = idx - (VC_WIDTH+1)'(VCS);
        if (!found && elig[idx[VC_WIDTH-1:0]]) begin
          grant[idx[VC_WIDTH-1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
    if (!i_rst_n) grant = '0;
  end

  always_comb begin
    gvc = '0;
    for (int v = 0; v < VCS; v++)
      if (grant[v]) gvc = VC_WIDTH'(v);
  end

  assign sel          = flit_t'(flits[gvc]);
  assign o_flit       = sel;
  assign o_vc         = gvc;
  assign o_flit_valid = |grant;
  assign o_flit_ready = grant & {VCS{i_flit_ready}};
  assign xfer         = o_flit_valid & i_flit_ready;

  always_comb begin
    logic [VC_WIDTH:0] nxt;
    state_d = state_q;
    lvc_d   = lvc_q;
    rr_d    = rr_q;
    nxt     = {1'b0, gvc} + (VC_WIDTH+1)'(1);
    if (nxt == (VC_WIDTH+1)'(VCS)) nxt = '0;
    if (xfer) begin
      if (state_q == ST_UNLOCKED && sel.head && !sel.tail) begin
        state_d = ST_LOCKED;
        lvc_d   = gvc;
      end else if (state_q == ST_LOCKED && sel.tail) begin
        state_d = ST_UNLOCKED;
      end
      if (sel.tail) rr_d = nxt[VC_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_UNLOCKED;
      lvc_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lvc_q   <= lvc_d;
      rr_q    <= rr_d;
    end
  end

`ifdef NOC_VC_ARB_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_flag_q, to_flag_d;

  // Counts consecutive idle locked cycles; saturates so the flag can't be missed.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_LOCKED && !xfer)
      to_cnt_d = (to_cnt_q == TW'(LOCK_TIMEOUT)) ? to_cnt_q : to_cnt_q + TW'(1);
    to_flag_d = to_flag_q | (to_cnt_d == TW'(LOCK_TIMEOUT));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign o_lock_timeout = to_flag_q;
`else
  assign o_lock_timeout = 1'b0;
`endif
endmodule
